// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Segment patterns are active-high, bit order gfedcba (bit0 = a).
package seven_seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b1111100;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b0111001;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b1011110;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b1110001;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Counter width that is never zero, so a count of 1 still gets a real register.
  function automatic int width_of(input int n);
    int w;
    w = clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seven_seg_encoder.sv
// Combinational nibble-to-segment decoder with BCD/hex selection and forced blank.
// Output is active-high; polarity is applied by the caller.
module seven_seg_encoder
  import seven_seg_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             hex_mode,
  input  logic             blank,
  output logic [SEG_W-1:0] pattern
);

  // Glyph lookup; BCD mode treats A..F as undisplayable.
  always_comb begin
    pattern = SEG_BLANK;
    if (blank) begin
      pattern = SEG_BLANK;
    end else if (!hex_mode && (nibble > 4'd9)) begin
      pattern = SEG_BLANK;
    end else begin
      case (nibble)
        4'h0:    pattern = SEG_0;
        4'h1:    pattern = SEG_1;
        4'h2:    pattern = SEG_2;
        4'h3:    pattern = SEG_3;
        4'h4:    pattern = SEG_4;
        4'h5:    pattern = SEG_5;
        4'h6:    pattern = SEG_6;
        4'h7:    pattern = SEG_7;
        4'h8:    pattern = SEG_8;
        4'h9:    pattern = SEG_9;
        4'hA:    pattern = SEG_A;
        4'hB:    pattern = SEG_B;
        4'hC:    pattern = SEG_C;
        4'hD:    pattern = SEG_D;
        4'hE:    pattern = SEG_E;
        4'hF:    pattern = SEG_F;
        default: pattern = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous
// double buffering, BCD/hex decode and leading-zero suppression.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  output logic [SEG_W-1:0]        seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IDX_W = width_of(NUM_DIGITS);
  localparam int PRE_W = width_of(CLK_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(CLK_DIV - 1);
  // XOR masks: applying the "off" pattern to an active-high value yields the pin polarity.
  localparam logic [SEG_W-1:0]      SEG_OFF = SEG_ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PRE_W-1:0]        prescaler_r;
  logic [IDX_W-1:0]        digit_idx_r;
  logic [4*NUM_DIGITS-1:0] disp_val_r;
  logic [NUM_DIGITS-1:0]   disp_dp_r;
  logic [4*NUM_DIGITS-1:0] pend_val_r;
  logic [NUM_DIGITS-1:0]   pend_dp_r;
  logic                    pend_valid_r;
  logic                    frame_done_r;
  logic [SEG_W-1:0]        seg_r;
  logic                    dp_r;
  logic [NUM_DIGITS-1:0]   an_r;

  logic                    tick_s;
  logic                    boundary_s;
  logic [NUM_DIGITS-1:0]   lz_s;
  logic                    lz_run_s;
  logic [3:0]              cur_nibble_s;
  logic                    cur_dp_s;
  logic                    cur_lz_s;
  logic [NUM_DIGITS-1:0]   an_sel_s;
  logic [SEG_W-1:0]        pattern_s;

  assign tick_s     = (prescaler_r == LAST_PRE);
  assign boundary_s = tick_s && (digit_idx_r == LAST_IDX);

  // Slot timing: prescaler, digit index and the frame-end pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_r  <= {PRE_W{1'b0}};
      digit_idx_r  <= {IDX_W{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= boundary_s;
      if (tick_s) begin
        prescaler_r <= {PRE_W{1'b0}};
        if (digit_idx_r == LAST_IDX) begin
          digit_idx_r <= {IDX_W{1'b0}};
        end else begin
          digit_idx_r <= digit_idx_r + IDX_W'(1);
        end
      end else begin
        prescaler_r <= prescaler_r + PRE_W'(1);
      end
    end
  end

  // Double buffer: loads park in pending and are committed only at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_val_r   <= {(4*NUM_DIGITS){1'b0}};
      disp_dp_r    <= {NUM_DIGITS{1'b0}};
      pend_val_r   <= {(4*NUM_DIGITS){1'b0}};
      pend_dp_r    <= {NUM_DIGITS{1'b0}};
      pend_valid_r <= 1'b0;
    end else begin
      if (boundary_s && load) begin
        disp_val_r   <= value;
        disp_dp_r    <= dp_in;
        pend_valid_r <= 1'b0;
      end else if (load) begin
        pend_val_r   <= value;
        pend_dp_r    <= dp_in;
        pend_valid_r <= 1'b1;
      end else if (boundary_s && pend_valid_r) begin
        disp_val_r   <= pend_val_r;
        disp_dp_r    <= pend_dp_r;
        pend_valid_r <= 1'b0;
      end else begin
        pend_valid_r <= pend_valid_r;
      end
    end
  end

  // Leading-zero mask, scanning from the most significant digit down.
  always_comb begin
    lz_run_s = 1'b1;
    lz_s     = {NUM_DIGITS{1'b0}};
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lz_run_s = lz_run_s & (disp_val_r[4*k +: 4] == 4'd0);
      lz_s[k]  = blank_lz & lz_run_s & (k != 0);
    end
  end

  // Select the current digit's nibble, dp and blank flag (AND-OR mux, one hit at most).
  always_comb begin
    cur_nibble_s = 4'd0;
    cur_dp_s     = 1'b0;
    cur_lz_s     = 1'b0;
    an_sel_s     = {NUM_DIGITS{1'b0}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_sel_s[k]  = (digit_idx_r == IDX_W'(k));
      cur_nibble_s = cur_nibble_s | (disp_val_r[4*k +: 4] & {4{an_sel_s[k]}});
      cur_dp_s     = cur_dp_s | (disp_dp_r[k] & an_sel_s[k]);
      cur_lz_s     = cur_lz_s | (lz_s[k] & an_sel_s[k]);
    end
  end

  seven_seg_encoder u_encoder (
    .nibble   (cur_nibble_s),
    .hex_mode (hex_mode),
    .blank    (cur_lz_s),
    .pattern  (pattern_s)
  );

  // Registered pin drivers, polarity-adjusted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= SEG_OFF;
      dp_r  <= DP_OFF;
      an_r  <= AN_OFF;
    end else begin
      seg_r <= pattern_s ^ SEG_OFF;
      dp_r  <= cur_dp_s ^ DP_OFF;
      an_r  <= an_sel_s ^ AN_OFF;
    end
  end

  assign seg        = seg_r;
  assign dp         = dp_r;
  assign an         = an_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomised scoreboard bench: a cycle-level reference model queues the expected
// pin state for every clock and a negedge monitor compares the DUT against it.
module tb_seven_seg_scan_driver;

  localparam int ND    = 4;
  localparam int CD    = 4;
  localparam int FRAME = ND * CD;

  localparam logic [6:0] FONT [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        hex_mode = 1'b0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  seven_seg_scan_driver #(
    .NUM_DIGITS(ND), .CLK_DIV(CD), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
    .hex_mode(hex_mode), .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_disp_dp, m_pend_dp;
  bit          m_pv;
  exp_t        m_e;
  int          m_d;
  logic [3:0]  m_nib;
  bit          m_blank;

  // Reference model: edge n after reset release shows slot ((n-1)/CD) mod ND; every
  // FRAME-th edge is a frame boundary where the buffered value becomes visible.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_disp = 16'h0; m_disp_dp = 4'h0; m_pend = 16'h0; m_pend_dp = 4'h0; m_pv = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      m_d     = ((cyc - 1) / CD) % ND;
      m_nib   = m_disp[4*m_d +: 4];
      m_blank = (blank_lz && m_d != 0 && (m_disp >> (4*m_d)) == 16'h0) || (!hex_mode && m_nib > 4'd9);
      m_e.seg = m_blank ? 7'b0000000 : FONT[m_nib];
      m_e.dp  = m_disp_dp[m_d];
      m_e.an  = ~(4'b0001 << m_d);
      m_e.fd  = (cyc % FRAME) == 0;
      exp_q.push_back(m_e);
      if (m_e.fd && load) begin
        m_disp = value; m_disp_dp = dp_in; m_pv = 1'b0;
      end else if (load) begin
        m_pend = value; m_pend_dp = dp_in; m_pv = 1'b1;
      end else if (m_e.fd && m_pv) begin
        m_disp = m_pend; m_disp_dp = m_pend_dp; m_pv = 1'b0;
      end
    end
  end

  exp_t mon_e;
  // Monitor: in reset (or before the first post-reset edge) everything must be off.
  always @(negedge clk) begin
    if (!rst_n || exp_q.size() == 0) mon_e = {7'b0000000, 1'b0, 4'b1111, 1'b0};
    else mon_e = exp_q.pop_front();
    tests++;
    if ({seg, dp, an, frame_done} !== mon_e) begin
      fails++;
      $display("FAIL scan t=%0t cyc=%0d got seg=%b dp=%b an=%b fd=%b required seg=%b dp=%b an=%b fd=%b",
               $time, cyc, seg, dp, an, frame_done, mon_e.seg, mon_e.dp, mon_e.an, mon_e.fd);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Advance until the next edge has the given frame phase; bounded.
  task automatic wait_phase(input int ph);
    int i;
    i = 0;
    while (((cyc + 1) % FRAME) != ph && i < FRAME + 2) begin
      @(negedge clk);
      i++;
    end
    if (((cyc + 1) % FRAME) != ph) begin
      tests++; fails++;
      $display("FAIL wait_phase got phase=%0d required %0d", (cyc + 1) % FRAME, ph);
    end
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    step(20);

    wait_phase(6);
    do_load(16'h1234, 4'h0);
    step(40);

    hex_mode = 1'b1; blank_lz = 1'b1;
    do_load(16'h00AF, 4'h0);
    step(36);
    hex_mode = 1'b0;
    step(20);

    do_load(16'h0000, 4'b0100);
    step(36);

    blank_lz = 1'b0;
    wait_phase(8);
    do_load(16'h1111, 4'h0);
    wait_phase(0);
    do_load(16'h5678, 4'h0);
    step(36);

    // Asynchronous reset in the middle of the digit-2 slot.
    wait_phase(11);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (an !== 4'b1111 || seg !== 7'b0000000 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL async_reset got an=%b seg=%b fd=%b required an=1111 seg=0000000 fd=0", an, seg, frame_done);
    end
    step(3);
    rst_n = 1'b1;
    step(24);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        value = 16'($urandom);
        if ($urandom_range(0, 1) == 0) value[15:8] = 8'h00;
        dp_in = 4'($urandom);
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) hex_mode = ~hex_mode;
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      @(negedge clk);
    end
    load = 1'b0;
    step(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
